mult_issue_ctrl: RTL and testbench
==================================

MULT_ISSUE_CTRL -- requirements
Module: mult_issue_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 64 (`WORD), the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low; the block is in reset while reset==0.
REQ-004 SHALL have port req_valid, input, 1: upstream presents a multiply request.
REQ-005 SHALL have port req_ready, output, 1: block accepts a request this cycle.
REQ-006 SHALL have ports req_a and req_b, input, SIZE each: multiplicand and multiplier.
REQ-007 SHALL have port req_mode, input, 2: 00 MUL low half; 10 SMULH; 01/11 UMULH.
REQ-008 SHALL have port req_rd, input, 5: destination register tag.
REQ-009 SHALL have port mul_start, output, 1: one-cycle launch pulse to the multiplier.
REQ-010 SHALL have ports mul_multiplicand and mul_multiplier, output, SIZE each, plus mul_mode, output, 2: latched operands and mode.
REQ-011 SHALL have ports mul_result, input, SIZE, and mul_done, input, 1: multiplier result and completion pulse.
REQ-012 SHALL have ports wb_valid, output, 1; wb_ready, input, 1; wb_data, output, SIZE; wb_rd, output, 5: writeback handshake.
REQ-013 SHALL have ports busy, output, 1 (state!=IDLE) and timeout_err, output, 1 (sticky error flag).

Function
REQ-014 SHALL implement FSM states IDLE, LAUNCH, WAIT, HOLD.
REQ-015 SHALL drive req_ready=1 in IDLE, req_ready=wb_ready in HOLD, and req_ready=0 in LAUNCH and WAIT.
REQ-016 SHALL accept a request when req_valid&&req_ready, latching req_a, req_b, req_mode and req_rd in the same cycle.
REQ-017 SHALL go to LAUNCH on accept when both operands are nonzero; mul_start=1 for exactly the one cycle spent in LAUNCH, then WAIT.
REQ-018 SHALL go directly to HOLD on accept when req_a==0 or req_b==0, with wb_data=0; mul_start is never pulsed for such a request.
REQ-019 SHALL, in WAIT, register mul_result into wb_data on the edge where mul_done==1 and go to HOLD.
REQ-020 SHALL keep a WAIT-cycle counter; if it reaches SIZE/2+4 without mul_done, it SHALL go to HOLD with wb_data=0 and set timeout_err.
REQ-021 SHALL keep timeout_err set until reset.
REQ-022 SHALL ignore mul_done outside WAIT.
REQ-023 SHALL drive wb_valid=1 exactly in HOLD; wb_data and wb_rd SHALL be stable while wb_valid&&!wb_ready.
REQ-024 SHALL, in HOLD with wb_ready=1: go to IDLE if there is no new request.
REQ-025 SHALL, in HOLD with wb_ready=1 and req_valid=1: accept the new request in that same cycle (back-to-back) and go to LAUNCH or HOLD per REQ-017/018.
REQ-026 SHALL hold mul_multiplicand, mul_multiplier and mul_mode constant from accept until the next accept.
REQ-027 SHALL give a latency from accept edge to wb_valid of: 1 cycle for zero bypass; 2 cycles plus the multiplier's done latency (SIZE/2+1) otherwise.

Reset
REQ-028 SHALL, while reset==0, force state=IDLE, mul_start=0, wb_valid=0, wb_data=0, wb_rd=0, operand and mode registers=0, counter=0, timeout_err=0, busy=0, req_ready=0.
REQ-029 SHALL abort any in-flight operation on reset asserted mid-operation; no wb_valid is produced for the aborted request after release.
REQ-030 SHALL present req_ready=1 in the first cycle after reset release.

Verification
REQ-031 Accept a=6, b=7, mode=00, rd=3 -> one mul_start pulse; model done after 33 cycles; then wb_valid=1, wb_data=42, wb_rd=3.
REQ-032 Accept a=0, b=5 -> mul_start stays 0; next cycle wb_valid=1, wb_data=0.
REQ-033 Hold wb_ready=0 for 10 cycles in HOLD -> wb_data and wb_rd stable and req_ready=0 throughout; then wb_ready=1 with req_valid=1 -> back-to-back accept in that same cycle.
REQ-034 Model never asserts mul_done -> after SIZE/2+4 WAIT cycles, wb_valid=1, wb_data=0, timeout_err=1 and sticky.
REQ-035 Assert reset during WAIT -> all outputs return to reset values immediately; a late mul_done after release causes no wb_valid.

Source files
------------

// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: issue/writeback controller in front of a multi-cycle multiplier.
// It accepts one request at a time and skips the multiplier when an operand is zero.
// A WAIT watchdog turns a missing mul_done into a zero result and a sticky error flag.
module mult_issue_ctrl #(
    parameter int SIZE = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [SIZE-1:0] req_a,
    input  logic [SIZE-1:0] req_b,
    input  logic [1:0]      req_mode,
    input  logic [4:0]      req_rd,
    output logic            mul_start,
    output logic [SIZE-1:0] mul_multiplicand,
    output logic [SIZE-1:0] mul_multiplier,
    output logic [1:0]      mul_mode,
    input  logic [SIZE-1:0] mul_result,
    input  logic            mul_done,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [SIZE-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            busy,
    output logic            timeout_err
);

    // Number of WAIT cycles allowed before the watchdog gives up on mul_done.
    localparam int TIMEOUT = SIZE / 2 + 4;
    localparam int CNT_W   = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            r_state;
    logic              r_mul_start;
    logic              r_wb_valid;
    logic              r_busy;
    logic              r_timeout_err;
    logic [CNT_W-1:0]  r_cnt;
    logic [SIZE-1:0]   r_a;
    logic [SIZE-1:0]   r_b;
    logic [1:0]        r_mode;
    logic [4:0]        r_rd;
    logic [SIZE-1:0]   r_wb_data;

    logic              w_req_ready;
    logic              w_accept;
    logic              w_zero_op;

    // Ready follows wb_ready in HOLD so a new request can be taken in the
    // very cycle the pending result drains; forced low while in reset.
    assign w_req_ready = reset && ((r_state == S_IDLE) ||
                                   ((r_state == S_HOLD) && wb_ready));
    assign w_accept    = req_valid && w_req_ready;
    assign w_zero_op   = (req_a == '0) || (req_b == '0);

    // Controller FSM: request latch, launch, wait/watchdog and writeback hold.
    // NOTE: every register here, datapath included, is cleared by the async reset
    // so an aborted operation leaves no stale operands or result behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_mul_start   <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_mode        <= 2'b00;
            r_rd          <= 5'd0;
            r_wb_data     <= '0;
        end else begin
            // NOTE: the launch pulse defaults low every cycle so it can only be
            // high for the single cycle after an accept.
            r_mul_start <= 1'b0;
            if (w_accept) begin
                // Only possible from IDLE or from HOLD while the result drains.
                r_a    <= req_a;
                r_b    <= req_b;
                r_mode <= req_mode;
                r_rd   <= req_rd;
                r_busy <= 1'b1;
                if (w_zero_op) begin
                    r_state    <= S_HOLD;
                    r_wb_data  <= '0;
                    r_wb_valid <= 1'b1;
                end else begin
                    r_state     <= S_LAUNCH;
                    r_mul_start <= 1'b1;
                    r_wb_valid  <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_LAUNCH: begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end
                    S_WAIT: begin
                        if (mul_done) begin
                            r_state    <= S_HOLD;
                            r_wb_data  <= mul_result;
                            r_wb_valid <= 1'b1;
                        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                            r_state       <= S_HOLD;
                            r_wb_data     <= '0;
                            r_wb_valid    <= 1'b1;
                            r_timeout_err <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (wb_ready) begin
                            r_state    <= S_IDLE;
                            r_wb_valid <= 1'b0;
                            r_busy     <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign req_ready        = w_req_ready;
    assign mul_start        = r_mul_start;
    assign mul_multiplicand = r_a;
    assign mul_multiplier   = r_b;
    assign mul_mode         = r_mode;
    assign wb_valid         = r_wb_valid;
    assign wb_data          = r_wb_data;
    assign wb_rd            = r_rd;
    assign busy             = r_busy;
    assign timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb_mult_issue_ctrl: directed bench for mult_issue_ctrl with a simple
// multiplier model that raises mul_done in the 33rd cycle after mul_start.
module tb_mult_issue_ctrl;

    localparam int SIZE = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [SIZE-1:0] req_a = '0;
    logic [SIZE-1:0] req_b = '0;
    logic [1:0]      req_mode = 2'b00;
    logic [4:0]      req_rd = 5'd0;
    logic            mul_start;
    logic [SIZE-1:0] mul_multiplicand;
    logic [SIZE-1:0] mul_multiplier;
    logic [1:0]      mul_mode;
    logic [SIZE-1:0] mul_result;
    logic            mul_done;
    logic            wb_valid;
    logic            wb_ready = 1'b1;
    logic [SIZE-1:0] wb_data;
    logic [4:0]      wb_rd;
    logic            busy;
    logic            timeout_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_edge = 0;

    mult_issue_ctrl #(.SIZE(SIZE)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_mode         (req_mode),
        .req_rd           (req_rd),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_mode         (mul_mode),
        .mul_result       (mul_result),
        .mul_done         (mul_done),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_data          (wb_data),
        .wb_rd            (wb_rd),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: done is high in the 33rd cycle after the start pulse.
    int              mdl_cnt = 0;
    bit              mdl_respond = 1'b1;
    logic            mdl_done = 1'b0;
    logic            tb_done = 1'b0;
    logic [SIZE-1:0] mdl_res = '0;

    assign mul_done   = mdl_done | tb_done;
    assign mul_result = mdl_res;

    function automatic logic [SIZE-1:0] ref_mul(input logic [SIZE-1:0] a,
                                                input logic [SIZE-1:0] b,
                                                input logic [1:0] m);
        logic [2*SIZE-1:0]        pu;
        logic signed [2*SIZE-1:0] ps;
        pu = {{SIZE{1'b0}}, a} * {{SIZE{1'b0}}, b};
        ps = $signed({{SIZE{a[SIZE-1]}}, a}) * $signed({{SIZE{b[SIZE-1]}}, b});
        if (m == 2'b00) return pu[SIZE-1:0];
        else if (m == 2'b10) return ps[2*SIZE-1:SIZE];
        else return pu[2*SIZE-1:SIZE];
    endfunction

    always @(negedge clk) begin
        mdl_done <= 1'b0;
        if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1 && mdl_respond) mdl_done <= 1'b1;
        end
        if (mul_start) begin
            mdl_cnt <= SIZE / 2 + 1;
            mdl_res <= ref_mul(mul_multiplicand, mul_multiplier, mul_mode);
        end
    end

    // Present a request; caller is just after a negedge. Accept edge is the next posedge.
    task automatic issue(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                         input logic [1:0] m, input logic [4:0] rd);
        req_a     = a;
        req_b     = b;
        req_mode  = m;
        req_rd    = rd;
        req_valid = 1'b1;
        acc_edge  = cyc;
    endtask

    // Wait (bounded) for wb_valid; latency counts edges from the accept edge.
    task automatic wait_wb(input int max_cyc, output int lat, output int starts, output bit ok);
        ok = 1'b0;
        starts = 0;
        lat = 0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mul_start) starts++;
            if (wb_valid) begin
                ok  = 1'b1;
                lat = cyc - acc_edge;
            end
        end
    endtask

    task automatic test_reset();
        int lat, starts;
        bit ok;
        req_valid = 1'b1;
        req_a = 64'd3;
        req_b = 64'd4;
        repeat (2) @(negedge clk);
        n_checks++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %0b expected 0", req_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b expected 0", busy); else n_pass++;
        n_checks++; if (wb_valid !== 1'b0) $display("FAIL rst_wb_valid: got %0b expected 0", wb_valid); else n_pass++;
        n_checks++; if (mul_start !== 1'b0) $display("FAIL rst_mul_start: got %0b expected 0", mul_start); else n_pass++;
        n_checks++; if (wb_data !== '0 || wb_rd !== 5'd0) $display("FAIL rst_wb: got %0h/%0d expected 0/0", wb_data, wb_rd); else n_pass++;
        n_checks++; if (mul_multiplicand !== '0 || mul_multiplier !== '0 || mul_mode !== 2'b00)
            $display("FAIL rst_operands: got %0h/%0h/%0b expected 0/0/0", mul_multiplicand, mul_multiplier, mul_mode); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err: got %0b expected 0", timeout_err); else n_pass++;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready: got %0b expected 1", req_ready); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || wb_valid !== 1'b0) $display("FAIL rst_release_idle: got busy=%0b wb_valid=%0b expected 0/0", busy, wb_valid); else n_pass++;
        ok = 1'b0; lat = 0; starts = 0;
    endtask

    task automatic test_mul();
        int lat, starts;
        bit ok;
        wb_ready = 1'b1;
        issue(64'd6, 64'd7, 2'b00, 5'd3);
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if (mul_start !== 1'b1) $display("FAIL mul_launch_pulse: got %0b expected 1", mul_start); else n_pass++;
        n_checks++; if (busy !== 1'b1 || req_ready !== 1'b0) $display("FAIL mul_launch_flags: got busy=%0b ready=%0b expected 1/0", busy, req_ready); else n_pass++;
        wait_wb(80, lat, starts, ok);
        n_checks++; if (!ok) $display("FAIL mul_wb_timeout: got no wb_valid expected wb_valid within 80 cycles"); else n_pass++;
        n_checks++; if (starts !== 0) $display("FAIL mul_extra_start: got %0d extra pulses expected 0", starts); else n_pass++;
        n_checks++; if (lat !== 35) $display("FAIL mul_latency: got %0d expected 35", lat); else n_pass++;
        n_checks++; if (wb_data !== 64'd42 || wb_rd !== 5'd3) $display("FAIL mul_result: got %0h/%0d expected 2a/3", wb_data, wb_rd); else n_pass++;
        n_checks++; if (mul_multiplicand !== 64'd6 || mul_multiplier !== 64'd7 || mul_mode !== 2'b00)
            $display("FAIL mul_operands: got %0h/%0h/%0b expected 6/7/0", mul_multiplicand, mul_multiplier, mul_mode); else n_pass++;
        @(negedge clk);
        n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL mul_drain: got valid=%0b busy=%0b ready=%0b expected 0/0/1", wb_valid, busy, req_ready); else n_pass++;
        // Signed high half: -1 * 2 = -2, upper word all ones.
        issue('1, 64'd2, 2'b10, 5'd1);
        wait_wb(80, lat, starts, ok);
        n_checks++; if (!ok || wb_data !== 64'hFFFF_FFFF_FFFF_FFFF)
            $display("FAIL smulh_result: got ok=%0b data=%0h expected 1/ffffffffffffffff", ok, wb_data); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_zero_bypass();
        int lat, starts;
        bit ok;
        issue(64'd0, 64'd5, 2'b00, 5'd9);
        wait_wb(5, lat, starts, ok);
        n_checks++; if (!ok || lat !== 1) $display("FAIL zero_a_latency: got ok=%0b lat=%0d expected 1/1", ok, lat); else n_pass++;
        n_checks++; if (starts !== 0) $display("FAIL zero_a_start: got %0d pulses expected 0", starts); else n_pass++;
        n_checks++; if (wb_data !== '0 || wb_rd !== 5'd9) $display("FAIL zero_a_result: got %0h/%0d expected 0/9", wb_data, wb_rd); else n_pass++;
        @(negedge clk);
        issue(64'h1234, 64'd0, 2'b01, 5'd10);
        wait_wb(5, lat, starts, ok);
        n_checks++; if (!ok || lat !== 1 || starts !== 0) $display("FAIL zero_b_bypass: got ok=%0b lat=%0d starts=%0d expected 1/1/0", ok, lat, starts); else n_pass++;
        n_checks++; if (wb_data !== '0 || wb_rd !== 5'd10) $display("FAIL zero_b_result: got %0h/%0d expected 0/10", wb_data, wb_rd); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, starts, bad;
        bit ok;
        wb_ready = 1'b0;
        issue(64'd3, 64'd5, 2'b00, 5'd12);
        wait_wb(80, lat, starts, ok);
        n_checks++; if (!ok || wb_data !== 64'd15) $display("FAIL hold_first: got ok=%0b data=%0h expected 1/f", ok, wb_data); else n_pass++;
        // Next request waits on the bus for the whole stall and must not be taken.
        req_a = '1;
        req_b = 64'd2;
        req_mode = 2'b01;
        req_rd = 5'd21;
        req_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wb_valid !== 1'b1 || wb_data !== 64'd15 || wb_rd !== 5'd12 || req_ready !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL hold_stable: got %0d bad cycles expected 0", bad); else n_pass++;
        wb_ready = 1'b1;
        acc_edge = cyc;
        #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL b2b_ready: got %0b expected 1", req_ready); else n_pass++;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if (mul_start !== 1'b1 || wb_valid !== 1'b0) $display("FAIL b2b_launch: got start=%0b valid=%0b expected 1/0", mul_start, wb_valid); else n_pass++;
        n_checks++; if (mul_multiplicand !== 64'hFFFF_FFFF_FFFF_FFFF || mul_mode !== 2'b01)
            $display("FAIL b2b_operands: got %0h/%0b expected ffffffffffffffff/1", mul_multiplicand, mul_mode); else n_pass++;
        wait_wb(80, lat, starts, ok);
        n_checks++; if (!ok || lat !== 35) $display("FAIL b2b_latency: got ok=%0b lat=%0d expected 1/35", ok, lat); else n_pass++;
        n_checks++; if (wb_data !== 64'd1 || wb_rd !== 5'd21) $display("FAIL umulh_result: got %0h/%0d expected 1/21", wb_data, wb_rd); else n_pass++;
        // Back-to-back zero bypass straight out of HOLD.
        issue(64'd0, 64'd9, 2'b00, 5'd7);
        wait_wb(3, lat, starts, ok);
        n_checks++; if (!ok || lat !== 1 || wb_data !== '0 || wb_rd !== 5'd7)
            $display("FAIL b2b_zero: got ok=%0b lat=%0d data=%0h rd=%0d expected 1/1/0/7", ok, lat, wb_data, wb_rd); else n_pass++;
        @(negedge clk);
        n_checks++; if (wb_valid !== 1'b0) $display("FAIL b2b_idle: got %0b expected 0", wb_valid); else n_pass++;
    endtask

    task automatic test_timeout();
        int lat, starts;
        bit ok;
        mdl_respond = 1'b0;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL to_initial: got %0b expected 0", timeout_err); else n_pass++;
        issue(64'd2, 64'd2, 2'b00, 5'd5);
        wait_wb(80, lat, starts, ok);
        n_checks++; if (!ok || lat !== 38) $display("FAIL to_latency: got ok=%0b lat=%0d expected 1/38", ok, lat); else n_pass++;
        n_checks++; if (wb_data !== '0 || wb_rd !== 5'd5) $display("FAIL to_result: got %0h/%0d expected 0/5", wb_data, wb_rd); else n_pass++;
        n_checks++; if (timeout_err !== 1'b1) $display("FAIL to_flag: got %0b expected 1", timeout_err); else n_pass++;
        mdl_respond = 1'b1;
        @(negedge clk);
        issue(64'd0, 64'd1, 2'b00, 5'd2);
        wait_wb(5, lat, starts, ok);
        @(negedge clk);
        n_checks++; if (timeout_err !== 1'b1) $display("FAIL to_sticky: got %0b expected 1", timeout_err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bad;
        issue(64'd6, 64'd7, 2'b00, 5'd3);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (busy !== 1'b1 || req_ready !== 1'b0) $display("FAIL mid_in_wait: got busy=%0b ready=%0b expected 1/0", busy, req_ready); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || wb_valid !== 1'b0 || req_ready !== 1'b0 || mul_start !== 1'b0)
            $display("FAIL mid_rst_flags: got busy=%0b valid=%0b ready=%0b start=%0b expected 0/0/0/0", busy, wb_valid, req_ready, mul_start); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL mid_rst_timeout_err: got %0b expected 0", timeout_err); else n_pass++;
        n_checks++; if (mul_multiplicand !== '0 || mul_multiplier !== '0 || wb_rd !== 5'd0 || wb_data !== '0)
            $display("FAIL mid_rst_regs: got %0h/%0h/%0d/%0h expected 0/0/0/0", mul_multiplicand, mul_multiplier, wb_rd, wb_data); else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        // The model is still counting and fires its late done; add a manual one too.
        bad = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            tb_done = (i == 3);
            if (wb_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        tb_done = 1'b0;
        n_checks++; if (bad !== 0) $display("FAIL mid_late_done: got %0d cycles with activity expected 0", bad); else n_pass++;
    endtask

    initial begin
        #2 reset = 1'b0;
        test_reset();
        test_mul();
        test_zero_bypass();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
